// File: rtl/noc_pkt_arbiter.sv
// Packet-granular round-robin arbiter for the shared upstream NoC link.
// Grant is held for a whole packet; a watchdog reclaims a starved grant.
module noc_pkt_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 15,
    parameter int SEL_W   = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] last,
    input  logic             link_rdy,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] pop,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             timeout_evt
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT - 1);
    localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(N_REQ - 1);

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [N_REQ-1:0] r_grant;
    logic [N_REQ-1:0] w_grant_nx;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] w_sel_nx;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] w_ptr_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             r_tevt;
    logic             w_tevt_nx;

    logic [N_REQ-1:0] w_pop;
    logic             w_own_pop;
    logic             w_own_req;
    logic             w_own_last;

    logic             w_hi_hit;
    logic [SEL_W-1:0] w_hi;
    logic [SEL_W-1:0] w_lo;
    logic [SEL_W-1:0] w_win;

    assign w_pop      = r_grant & req & {N_REQ{link_rdy}};
    assign w_own_pop  = |w_pop;
    assign w_own_req  = |(r_grant & req);
    assign w_own_last = |(w_pop & last);

    // Lowest requester above ptr wins; otherwise wrap to lowest overall.
    always_comb begin
        w_hi_hit = 1'b0;
        w_hi     = '0;
        w_lo     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (SEL_W'(i) > r_ptr) begin
                    w_hi_hit = 1'b1;
                    w_hi     = SEL_W'(i);
                end else begin
                    w_lo = SEL_W'(i);
                end
            end
        end
        w_win = w_hi_hit ? w_hi : w_lo;
    end

    always_comb begin
        w_state_nx = r_state;
        w_grant_nx = r_grant;
        w_sel_nx   = r_sel;
        w_ptr_nx   = r_ptr;
        w_cnt_nx   = r_cnt;
        w_tevt_nx  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (|req) begin
                    w_state_nx = XFER;
                    w_grant_nx = N_REQ'(1) << w_win;
                    w_sel_nx   = w_win;
                    w_cnt_nx   = '0;
                end
            end
            XFER: begin
                if (w_own_pop) begin
                    w_cnt_nx = '0;
                    if (w_own_last) begin
                        w_state_nx = IDLE;
                        w_grant_nx = '0;
                        w_ptr_nx   = r_sel;
                    end
                end else if (!w_own_req) begin
                    if (r_cnt == CNT_LIM) begin
                        w_state_nx = IDLE;
                        w_grant_nx = '0;
                        w_ptr_nx   = r_sel;
                        w_cnt_nx   = '0;
                        w_tevt_nx  = 1'b1;
                    end else if (r_cnt != CNT_MAX) begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_sel   <= '0;
            r_ptr   <= PTR_RST;
            r_cnt   <= '0;
            r_tevt  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_grant <= w_grant_nx;
            r_sel   <= w_sel_nx;
            r_ptr   <= w_ptr_nx;
            r_cnt   <= w_cnt_nx;
            r_tevt  <= w_tevt_nx;
        end
    end

    assign grant       = r_grant;
    assign pop         = w_pop;
    assign sel         = r_sel;
    assign busy        = (r_state == XFER);
    assign timeout_evt = r_tevt;

endmodule

// File: doc/noc_pkt_arbiter.md
Name: noc_pkt_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single upstream NoC link (noc_from_dev_ctl/data) among N_REQ slave response FIFOs.
- Holds a grant for a whole packet and releases it on that packet's last beat.
- Issues pop strobes to the owning FIFO and an encoded select for the switch's output data mux.
- Watchdog forces release when the owner starves mid-packet.

Parameters:
N_REQ, 4, number of requesting FIFOs (2..8)
TIMEOUT, 15, consecutive owner-empty cycles mid-packet before forced release (1..255)
SEL_W, $clog2(N_REQ), width of sel

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
req  in  N_REQ  bit i = FIFO i non-empty (head beat valid)
last  in  N_REQ  bit i = FIFO i head beat is final beat of its packet; meaningful only when req[i]=1
link_rdy  in  1  downstream link accepts a beat this cycle
grant  out  N_REQ  one-hot registered owner; all-zero when idle
pop  out  N_REQ  combinational; pop[i] = grant[i] & req[i] & link_rdy
sel  out  SEL_W  registered binary index of owner; holds last owner when idle
busy  out  1  registered; 1 while in XFER
timeout_evt  out  1  registered one-cycle pulse on forced release

Behaviour:
- Reset values: grant=0, sel=0, busy=0, timeout_evt=0, state=IDLE, watchdog cnt=0, rr pointer ptr=N_REQ-1 (requester 0 has first priority). pop=0 follows from grant=0.
- Reset mid-packet: same values immediately. No pop is issued during reset. A partially sent packet is not replayed.
- State IDLE:
  - If req!=0, winner = first i with req[i]=1, scanning ptr+1, ptr+2, ... modulo N_REQ.
  - Next edge: grant=onehot(winner), sel=winner, busy=1, cnt=0, state=XFER.
  - Latency req-to-grant = 1 cycle. The first pop can occur in the first XFER cycle.
  - If req==0, stay in IDLE.
- State XFER, owner o:
  - Beat transfer: a pop[o] cycle. Owner-empty: a cycle with req[o]=0.
  - pop[o] with last[o]=1: next edge grant=0, busy=0, ptr=o, state=IDLE. Minimum one IDLE cycle between packets (re-arbitration slot).
  - pop[o] with last[o]=0: cnt=0, remain in XFER.
  - req[o]=0: cnt=cnt+1.
  - req[o]=1 and link_rdy=0: cnt holds. Backpressure is not owner fault.
  - cnt reaches TIMEOUT (the cnt==TIMEOUT-1 cycle has req[o]=0): next edge forced release as for last beat, ptr=o, timeout_evt=1 for exactly one cycle.
  - Requests from other FIFOs are ignored while in XFER. No preemption.
- Arithmetic: cnt width $clog2(TIMEOUT+1), saturates and never wraps. ptr wraps modulo N_REQ. sel is always consistent with grant when busy=1.
- Simultaneous events:
  - Last-beat pop and cnt threshold cannot coincide, because a pop clears the count path. Normal release wins and timeout_evt=0.
  - Owner req dropping in the same edge grant is registered: owner keeps the grant and cnt starts counting.
- Invariants: grant is one-hot or zero. pop is a subset of grant. At most one pop bit is high per cycle.

Test Plan:
- Reset release, req=0001, last=0001, link_rdy=1 -> cycle 1 grant=0001, sel=0, busy=1, pop=0001; cycle 2 grant=0, busy=0, ptr=0.
- All req=1111, every packet 3 beats, link_rdy=1 -> grant order 0001,0010,0100,1000,0001. Each grant lasts 3 cycles, separated by 1 idle cycle.
- Owner 2 mid-packet, link_rdy=0 for 20 cycles with req[2]=1 -> no pops, no timeout_evt, grant stays 0100. When link_rdy=1 the beats resume.
- Owner 1 after 1 beat, req[1]=0 for 15 cycles, TIMEOUT=15 -> timeout_evt pulses once, next cycle grant=0, ptr=1. A following req=0011 then grants 0001.
- Owner 3 holding, req=1111 -> grant remains 1000 until the last beat, no preemption. Next winner is 0001 (wrap).
- Assert reset during the 2nd beat of a 4-beat packet -> grant/pop/busy drop to 0 immediately. After release, req=0100 is granted with the ptr reset order (0 first when present).
